// File: rtl/m_definitions_pkg.sv
// Shared M-unit definitions: RV32M encoding constants, funct3 codes and the
// issue-controller state type.
package m_definitions;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } m_func3_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WB    = 3'd4
    } issue_state_t;

    function automatic logic is_rv32m(input logic [31:0] instr);
        return (instr[6:0] == OPCODE_OP) && (instr[31:25] == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/m_issue_ctrl_wb_buffer.sv
// m_wb_buffer: single-entry writeback holding register; data/index are captured
// independently of the valid flag, which clears on handshake or flush.
module m_wb_buffer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            capture,
    input  logic            set_valid,
    input  logic [XLEN-1:0] data_in,
    input  logic [4:0]      idx_in,
    input  logic            flush,
    input  logic            ready,
    output logic            valid,
    output logic [XLEN-1:0] data,
    output logic [4:0]      idx
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
            idx   <= '0;
        end else begin
            if (capture) begin
                data <= data_in;
                idx  <= idx_in;
            end
            if (flush || (valid && ready)) begin
                valid <= 1'b0;
            end else if (set_valid) begin
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/m_issue_ctrl.sv
// m_issue_ctrl: issues one RV32M transaction at a time to the M unit and hands
// the result to writeback. Define M_ISSUE_TIMEOUT_EN to enable the WAIT/DRAIN abort timer.
module m_issue_ctrl
    import m_definitions::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_instruction,
    input  logic [XLEN-1:0] req_rs1_val,
    input  logic [XLEN-1:0] req_rs2_val,
    output logic            illegal,
    output logic            stall,
    input  logic            flush,
    output logic            m_valid,
    output logic [31:0]     m_instruction,
    output logic [XLEN-1:0] m_rs1,
    output logic [XLEN-1:0] m_rs2,
    input  logic            m_wr,
    input  logic [XLEN-1:0] m_rd,
    input  logic            m_busy,
    input  logic            m_ready,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd_idx,
    output logic [XLEN-1:0] wb_data,
    output logic            err_timeout
);

    // state | meaning
    // IDLE  | accepting requests (unless the M unit still reports busy)
    // ISSUE | one-cycle m_valid with latched instruction/operands
    // WAIT  | waiting for m_ready; result goes to WB or is dropped
    // DRAIN | flushed; M unit cannot be aborted, discard its result
    // WB    | result held until the regfile accepts or flush

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    issue_state_t   state_q, state_d;
    logic [4:0]     rd_idx_q;
    logic           illegal_q;
    logic           accept;
    logic           legal;
    logic           capture;
    logic           set_valid;
    logic           tmr_expired;

    assign accept    = (state_q == ST_IDLE) && !m_busy && req_valid;
    assign legal     = is_rv32m(req_instruction);
    assign req_ready = (state_q == ST_IDLE) && !m_busy;
    assign stall     = (state_q != ST_IDLE);
    assign m_valid   = (state_q == ST_ISSUE);
    assign illegal   = illegal_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            illegal_q     <= 1'b0;
            m_instruction <= '0;
            m_rs1         <= '0;
            m_rs2         <= '0;
            rd_idx_q      <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= accept && !legal;
            if (accept && legal) begin
                m_instruction <= req_instruction;
                m_rs1         <= req_rs1_val;
                m_rs2         <= req_rs2_val;
                rd_idx_q      <= req_instruction[11:7];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        set_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && legal) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                // flush racing the result drops it
                if (m_ready) begin
                    state_d = ST_IDLE;
                    if (!flush) begin
                        capture = 1'b1;
                        if (m_wr && (rd_idx_q != 5'd0)) begin
                            set_valid = 1'b1;
                            state_d   = ST_WB;
                        end
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (m_ready || tmr_expired) state_d = ST_IDLE;
            end
            ST_WB: begin
                if (flush || wb_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    m_wb_buffer #(
        .XLEN(XLEN)
    ) u_wb_buffer (
        .clk       (clk),
        .resetn    (resetn),
        .capture   (capture),
        .set_valid (set_valid),
        .data_in   (m_rd),
        .idx_in    (rd_idx_q),
        .flush     (flush && (state_q == ST_WB)),
        .ready     (wb_ready),
        .valid     (wb_valid),
        .data      (wb_data),
        .idx       (wb_rd_idx)
    );

`ifdef M_ISSUE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] tmr_q;
    logic          tmr_load;
    logic          err_timeout_q;

    // Reloaded on every entry into WAIT or DRAIN; terminal count is zero.
    assign tmr_load    = (state_q == ST_ISSUE) ||
                         ((state_q == ST_WAIT) && flush && !m_ready);
    assign tmr_expired = (tmr_q == '0);
    assign err_timeout = err_timeout_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmr_q         <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= tmr_expired && !m_ready &&
                             (((state_q == ST_WAIT) && !flush) || (state_q == ST_DRAIN));
            if (tmr_load) begin
                tmr_q <= TW'(TIMEOUT_CYCLES - 1);
            end else if (tmr_q != '0) begin
                tmr_q <= tmr_q - 1'b1;
            end
        end
    end
`else
    assign tmr_expired = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_m_issue_ctrl.sv
// Scoreboard bench for m_issue_ctrl with a behavioural RV32M unit model and
// randomized requests, flushes and writeback backpressure.
module tb_m_issue_ctrl;
    import m_definitions::*;

    localparam int XLEN = 32;
    localparam int TMO  = 8;

    localparam int MD_NONE = 0;
    localparam int MD_HOLD = 1;
    localparam int MD_FLIS = 2;
    localparam int MD_FLWT = 3;
    localparam int MD_FLWB = 4;
    localparam int MD_RST  = 5;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [31:0]     req_instruction = '0;
    logic [XLEN-1:0] req_rs1_val = '0;
    logic [XLEN-1:0] req_rs2_val = '0;
    logic            illegal;
    logic            stall;
    logic            flush = 1'b0;
    logic            m_valid;
    logic [31:0]     m_instruction;
    logic [XLEN-1:0] m_rs1;
    logic [XLEN-1:0] m_rs2;
    logic            m_wr = 1'b0;
    logic [XLEN-1:0] m_rd = '0;
    logic            m_busy;
    logic            m_ready = 1'b0;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd_idx;
    logic [XLEN-1:0] wb_data;
    logic            err_timeout;

    logic unit_busy = 1'b0;
    logic stale_busy = 1'b0;
    logic wb_ready_rnd = 1'b0;
    logic wb_hold = 1'b0;
    logic next_wr = 1'b1;
    logic unit_mute = 1'b0;

    assign m_busy   = unit_busy | stale_busy;
    assign wb_ready = wb_ready_rnd & ~wb_hold;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } iss_t;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } wb_t;

    iss_t        iss_q[$];
    wb_t         wb_q[$];
    logic [31:0] ill_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    m_issue_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .XLEN(XLEN)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instruction(req_instruction), .req_rs1_val(req_rs1_val), .req_rs2_val(req_rs2_val),
        .illegal(illegal), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_instruction(m_instruction), .m_rs1(m_rs1), .m_rs2(m_rs2),
        .m_wr(m_wr), .m_rd(m_rd), .m_busy(m_busy), .m_ready(m_ready),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_idx(wb_rd_idx), .wb_data(wb_data),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules, in 64-bit arithmetic.
    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (m_func3_t'(f3))
            F3_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
            F3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            F3_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            F3_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            F3_REMU:   return (b == 0) ? a : a % b;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, OPCODE_OP};
    endfunction

    // Behavioural M unit: random latency, result computed from what it was issued.
    initial begin : unit_model
        logic [31:0] a, b;
        logic [2:0]  f3;
        int          lat;
        forever begin
            @(negedge clk);
            if (m_valid && resetn) begin
                a   = m_rs1;
                b   = m_rs2;
                f3  = m_instruction[14:12];
                lat = $urandom_range(1, 4);
                if ($urandom_range(0, 1) == 1) begin
                    m_ready = 1'b1;
                    m_wr    = 1'b1;
                    m_rd    = 32'hBAD0_BAD0;
                end
                @(posedge clk); #1;
                m_ready = 1'b0;
                m_wr    = 1'b0;
                if (!unit_mute) begin
                    unit_busy = 1'b1;
                    repeat (lat - 1) begin @(posedge clk); #1; end
                    unit_busy = 1'b0;
                    m_ready   = 1'b1;
                    m_wr      = next_wr;
                    m_rd      = ref_m(f3, a, b);
                    @(posedge clk); #1;
                    m_ready = 1'b0;
                    m_wr    = 1'b0;
                end
            end
        end
    end

    initial begin : wb_ready_gen
        forever begin
            @(posedge clk); #1;
            wb_ready_rnd = ($urandom_range(0, 9) < 7);
        end
    end

    initial begin : monitor
        logic        pv, pr, pf;
        logic [31:0] pd;
        logic [4:0]  pi;
        iss_t        ei;
        wb_t         ew;
        logic [31:0] el;
        pv = 1'b0; pr = 1'b0; pf = 1'b0; pd = '0; pi = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pv = 1'b0;
                continue;
            end
            if (m_valid) begin
                if (iss_q.size() == 0) check("unexpected_m_valid", m_valid, 1'b0);
                else begin
                    ei = iss_q.pop_front();
                    check("m_instruction", m_instruction, ei.instr);
                    check("m_rs1", m_rs1, ei.rs1);
                    check("m_rs2", m_rs2, ei.rs2);
                end
            end
            if (illegal) begin
                if (ill_q.size() == 0) check("unexpected_illegal", illegal, 1'b0);
                else el = ill_q.pop_front();
            end
            if (wb_valid && wb_ready) begin
                if (wb_q.size() == 0) check("unexpected_wb", wb_valid, 1'b0);
                else begin
                    ew = wb_q.pop_front();
                    check("wb_rd_idx", wb_rd_idx, ew.idx);
                    check("wb_data", wb_data, ew.data);
                end
            end
            if (pv && !pr && !pf) begin
                check("wb_valid_held", wb_valid, 1'b1);
                check("wb_data_stable", wb_data, pd);
                check("wb_idx_stable", wb_rd_idx, pi);
            end
            check("req_ready_rule", req_ready, !stall && !m_busy);
            if (wb_valid) check("wb_stall_ready", {stall, req_ready}, 2'b10);
`ifndef M_ISSUE_TIMEOUT_EN
            check("err_timeout_zero", err_timeout, 1'b0);
`endif
            pv = wb_valid; pr = wb_ready; pf = flush; pd = wb_data; pi = wb_rd_idx;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) check("req_ready_wait", req_ready, 1'b1);
    endtask

    task automatic wait_wb();
        int n;
        n = 0;
        @(negedge clk);
        while (!wb_valid && n < 200) begin @(negedge clk); n++; end
        if (!wb_valid) check("wb_valid_wait", wb_valid, 1'b1);
    endtask

    task automatic do_txn(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                          input int mode_in, input logic wr);
        bit         legal;
        logic [4:0] rd;
        int         mode;
        mode  = mode_in;
        legal = (instr[6:0] == OPCODE_OP) && (instr[31:25] == FUNCT7_MULDIV);
        rd    = instr[11:7];
        if ((mode == MD_HOLD || mode == MD_FLWB) && !(wr && rd != 0)) mode = MD_NONE;
        wait_ready();
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            wait_ready();
        end
        next_wr         = wr;
        req_valid       = 1'b1;
        req_instruction = instr;
        req_rs1_val     = a;
        req_rs2_val     = b;
        if (!legal) ill_q.push_back(instr);
        else begin
            iss_q.push_back('{instr, a, b});
            if (wr && rd != 0 && (mode == MD_NONE || mode == MD_HOLD))
                wb_q.push_back('{rd, ref_m(instr[14:12], a, b)});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!legal) begin
            @(negedge clk);
            check("illegal_keeps_ready", req_ready, 1'b1);
            return;
        end
        case (mode)
            MD_HOLD: begin
                wb_hold = 1'b1;
                wait_wb();
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("hold_wb_valid", {wb_valid, stall, req_ready}, 3'b110);
                end
                @(posedge clk); #1;
                wb_hold = 1'b0;
            end
            MD_FLIS: begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
            end
            MD_FLWT: begin
                @(posedge clk); #1;
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
            end
            MD_FLWB: begin
                wb_hold = 1'b1;
                wait_wb();
                @(posedge clk); #1;
                flush = 1'b1;
                @(posedge clk); #1;
                flush   = 1'b0;
                wb_hold = 1'b0;
                @(negedge clk);
                check("wb_flush_drop", wb_valid, 1'b0);
            end
            MD_RST: begin
                @(posedge clk); #1;
                resetn = 1'b0;
                @(posedge clk); #1;
                resetn = 1'b1;
                @(negedge clk);
                check("rst_abandon", {wb_valid, stall}, 2'b00);
            end
            default: ;
        endcase
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] instr, a, b;
        int          sel, mode;
        logic        wr;

        @(negedge clk);
        check("rst_outputs", {m_valid, wb_valid, illegal, err_timeout, stall, req_ready}, 6'b000001);
        check("rst_m_instruction", m_instruction, 32'd0);
        check("rst_m_ops", {m_rs1, m_rs2}, 64'd0);
        check("rst_wb", {wb_rd_idx, wb_data}, 37'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        do_txn(mk(FUNCT7_MULDIV, F3_MUL, 5'd5), 32'h1111_FFFF, 32'h1111_FFFF, MD_NONE, 1'b1);
        do_txn(mk(FUNCT7_MULDIV, F3_DIV, 5'd7), 32'hFFFF_FFF3, 32'h0000_0000, MD_NONE, 1'b1);
        do_txn(mk(FUNCT7_MULDIV, F3_REMU, 5'd3), 32'h0000_000D, 32'h0000_0005, MD_HOLD, 1'b1);
        do_txn(mk(7'b0000000, 3'b000, 5'd9), 32'd1, 32'd2, MD_NONE, 1'b1);
        do_txn(mk(FUNCT7_MULDIV, F3_MULHU, 5'd0), 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD_NONE, 1'b1);
        do_txn(mk(FUNCT7_MULDIV, F3_MUL, 5'd4), 32'd6, 32'd7, MD_FLWT, 1'b1);
        do_txn(mk(FUNCT7_MULDIV, F3_DIV, 5'd8), 32'h8000_0000, 32'hFFFF_FFFF, MD_NONE, 1'b1);
        do_txn(mk(FUNCT7_MULDIV, F3_REM, 5'd9), 32'h8000_0000, 32'hFFFF_FFFF, MD_FLWB, 1'b1);
        do_txn(mk(FUNCT7_MULDIV, F3_MULH, 5'd10), 32'h8000_0000, 32'd2, MD_RST, 1'b1);

        // A stale busy unit must hold off acceptance even with a pending request.
        wait_ready();
        @(posedge clk); #1;
        stale_busy      = 1'b1;
        req_valid       = 1'b1;
        req_instruction = mk(FUNCT7_MULDIV, F3_MUL, 5'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_blocks_ready", {req_ready, stall}, 2'b00);
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        stale_busy = 1'b0;

`ifdef M_ISSUE_TIMEOUT_EN
        wait_ready();
        unit_mute       = 1'b1;
        req_valid       = 1'b1;
        req_instruction = mk(FUNCT7_MULDIV, F3_DIVU, 5'd11);
        req_rs1_val     = 32'd100;
        req_rs2_val     = 32'd7;
        iss_q.push_back('{req_instruction, req_rs1_val, req_rs2_val});
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            check("timeout_early", err_timeout, 1'b0);
        end
        @(negedge clk);
        check("timeout_pulse", {err_timeout, stall, wb_valid}, 3'b100);
        @(negedge clk);
        check("timeout_one_cycle", err_timeout, 1'b0);
        unit_mute = 1'b0;
`endif

        for (int t = 0; t < 150; t++) begin
            sel = $urandom_range(0, 99);
            instr = {FUNCT7_MULDIV, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), OPCODE_OP};
            if (sel < 12) instr = $urandom;
            else if (sel < 18) instr[31:25] = 7'($urandom_range(2, 127));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            wr = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 19))
                0, 1:    mode = MD_HOLD;
                2, 3:    mode = MD_FLIS;
                4, 5:    mode = MD_FLWT;
                6, 7:    mode = MD_FLWB;
                8:       mode = MD_RST;
                default: mode = MD_NONE;
            endcase
            do_txn(instr, a, b, mode, wr);
        end

        wait_ready();
        repeat (10) @(negedge clk);
        check("iss_q_drained", 64'(iss_q.size()), 64'd0);
        check("wb_q_drained", 64'(wb_q.size()), 64'd0);
        check("ill_q_drained", 64'(ill_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
